// File: rtl/jkff_bank_sequencer.sv
// Command-driven sequencer for a bank of JK flip-flops. It loads, toggles, or counts
// the bank by steering each cell's j/k inputs. Only one command is in flight at a time.

module jkff_bank_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_reg <= 1'b0;
                2'b10:   q_reg <= 1'b1;
                2'b11:   q_reg <= ~q_reg;
                default: q_reg <= q_reg;
            endcase
        end
    end

    assign q = q_reg;

endmodule

module jkff_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_UP     = 2'b10;
    localparam logic [1:0] OP_DOWN   = 2'b11;

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] step_cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] q_cells;
    logic [WIDTH-1:0] up_en;
    logic [WIDTH-1:0] dn_en;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic             accept;
    logic             is_count;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign is_count  = cmd_op[1];

    // Bit i flips on count-up when all lower bits are 1, on count-down when all are 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_count_en
            if (gi == 0) begin : g_lsb
                assign up_en[gi] = 1'b1;
                assign dn_en[gi] = 1'b1;
            end else begin : g_upper
                assign up_en[gi] = &q_cells[gi-1:0];
                assign dn_en[gi] = &(~q_cells[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        j_next = '0;
        k_next = '0;
        if (state_reg == ST_EXEC) begin
            case (op_reg)
                OP_LOAD: begin
                    j_next = data_reg;
                    k_next = ~data_reg;
                end
                OP_TOGGLE: begin
                    j_next = data_reg;
                    k_next = data_reg;
                end
                OP_UP: begin
                    j_next = up_en;
                    k_next = up_en;
                end
                OP_DOWN: begin
                    j_next = dn_en;
                    k_next = dn_en;
                end
                default: begin
                    j_next = '0;
                    k_next = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
            jkff_bank_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (j_next[gi]),
                .k     (k_next[gi]),
                .q     (q_cells[gi])
            );
        end
    endgenerate

    // A zero-step count skips EXEC entirely; the bank is never enabled for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_LOAD;
            data_reg     <= '0;
            step_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        op_reg       <= cmd_op;
                        data_reg     <= cmd_data;
                        step_cnt_reg <= is_count ? cmd_steps : '0;
                        busy_reg     <= 1'b1;
                        if (is_count && (cmd_steps == '0)) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (op_reg[1]) begin
                        step_cnt_reg <= step_cnt_reg - CNT_W'(1);
                    end
                    if (!op_reg[1] || (step_cnt_reg <= CNT_W'(1))) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_cells;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_jkff_bank_sequencer.sv
// Directed and randomized stimulus checked each cycle against a timeline model:
// each accepted command expands into the list of (q, done) values seen after each edge.

module tb_jkff_bank_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_steps;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q;
    bit               m_busy;
    bit               m_done;
    logic [WIDTH-1:0] fifo_q[$];
    bit               fifo_done[$];

    jkff_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expand a command into the observable (q, done) after each edge, starting at the accept edge.
    task automatic model_accept(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                input logic [CNT_W-1:0] s);
        int steps;
        steps = int'(s);
        case (op)
            2'b00: begin
                fifo_q.push_back(m_q);           fifo_done.push_back(1'b0);
                fifo_q.push_back(d);             fifo_done.push_back(1'b1);
            end
            2'b01: begin
                fifo_q.push_back(m_q);           fifo_done.push_back(1'b0);
                fifo_q.push_back(m_q ^ d);       fifo_done.push_back(1'b1);
            end
            default: begin
                if (steps == 0) begin
                    fifo_q.push_back(m_q);       fifo_done.push_back(1'b1);
                end else begin
                    fifo_q.push_back(m_q);       fifo_done.push_back(1'b0);
                    for (int n = 1; n <= steps; n++) begin
                        if (op == 2'b10) fifo_q.push_back(WIDTH'(int'(m_q) + n));
                        else             fifo_q.push_back(WIDTH'(int'(m_q) - n));
                        fifo_done.push_back(n == steps);
                    end
                end
            end
        endcase
    endtask

    task automatic model_edge(input logic rst, input logic v, input logic [1:0] op,
                              input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] s);
        if (rst) begin
            m_q = '0; m_busy = 0; m_done = 0;
            fifo_q.delete(); fifo_done.delete();
        end else if (m_busy) begin
            if (fifo_q.size() > 0) begin
                m_q = fifo_q.pop_front();
                m_done = fifo_done.pop_front();
            end else begin
                m_busy = 0; m_done = 0;
            end
        end else if (v) begin
            model_accept(op, d, s);
            m_busy = 1;
            m_q = fifo_q.pop_front();
            m_done = fifo_done.pop_front();
        end else begin
            m_done = 0;
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] s);
        reset = rst; cmd_valid = v; cmd_op = op; cmd_data = d; cmd_steps = s;
        model_edge(rst, v, op, d, s);
        @(posedge clk);
        #1;
        check_val("q", 32'(q), 32'(m_q));
        check_val("ready", 32'(cmd_ready), 32'(!m_busy));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("done", 32'(done), 32'(m_done));
        $display("cyc t=%0t rst=%0b v=%0b op=%0d d=%02h s=%0d -> q=%02h rdy=%0b busy=%0b done=%0b",
                 $time, rst, v, op, d, s, q, cmd_ready, busy, done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 8'h00, 8'd0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_steps = '0;
        m_q = '0; m_busy = 0; m_done = 0;

        cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'd0);
        cycle(1'b1, 1'b1, 2'b01, 8'hFF, 8'd3);
        check_val("reset_q", 32'(q), 32'h0);
        check_val("reset_ready", 32'(cmd_ready), 32'h1);

        // LOAD A5, then toggles
        cycle(1'b0, 1'b1, 2'b00, 8'hA5, 8'd0);
        idle(3);
        check_val("load_a5", 32'(q), 32'hA5);
        cycle(1'b0, 1'b1, 2'b01, 8'h0F, 8'd0);
        idle(3);
        check_val("toggle_0f", 32'(q), 32'hAA);
        cycle(1'b0, 1'b1, 2'b01, 8'h00, 8'd0);
        idle(3);

        // Count up across the wrap, then count down across zero
        cycle(1'b0, 1'b1, 2'b00, 8'hFD, 8'd0);
        idle(3);
        cycle(1'b0, 1'b1, 2'b10, 8'h00, 8'd4);
        idle(6);
        check_val("up_wrap", 32'(q), 32'h01);
        cycle(1'b0, 1'b1, 2'b00, 8'h01, 8'd0);
        idle(3);
        cycle(1'b0, 1'b1, 2'b11, 8'h00, 8'd3);
        idle(5);
        check_val("down_wrap", 32'(q), 32'hFE);
        cycle(1'b0, 1'b1, 2'b10, 8'h00, 8'd0);
        idle(3);

        // Reset mid-count
        cycle(1'b0, 1'b1, 2'b00, 8'h00, 8'd0);
        idle(3);
        cycle(1'b0, 1'b1, 2'b10, 8'h00, 8'd10);
        idle(3);
        cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'd0);
        check_val("abort_q", 32'(q), 32'h0);
        idle(2);

        // Valid held high with changing payload
        for (int i = 0; i < 12; i++)
            cycle(1'b0, 1'b1, 2'($urandom_range(0, 1)), 8'($urandom), 8'd0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) < 7),
                  2'($urandom), 8'($urandom),
                  ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
